// File: rtl/stream_packet_fifo_if.sv
// Avalon-ST packet stream bundle; master drives payload and valid, slave drives ready.
interface stream_packet_fifo_if #(
   parameter int DATA_BYTES = 8
);
   localparam int EMPTY_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   logic [DATA_BYTES*8-1:0] data;
   logic [EMPTY_W-1:0]      empty;
   logic                    valid;
   logic                    startofpacket;
   logic                    endofpacket;
   logic                    ready;

   modport master (output data, empty, valid, startofpacket, endofpacket, input ready);
   modport slave  (input data, empty, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet buffer: packets become visible only after their EOP beat is stored.
// Optional drop statistics counter enabled by defining STREAM_PACKET_FIFO_STATS_EN.
module stream_packet_fifo #(
   parameter int DATA_BYTES = 8,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   stream_packet_fifo_if.slave   stream_in,
   stream_packet_fifo_if.master  stream_out,
   output logic [DEPTH_LOG2:0]   fill_level,
   output logic [15:0]           drop_count
);
   localparam int DATA_W  = DATA_BYTES * 8;
   localparam int EMPTY_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam int ENTRY_W = DATA_W + EMPTY_W + 2;
   localparam int DEPTH   = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] PTR_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   logic [ENTRY_W-1:0]    mem_r [DEPTH];
   logic [DEPTH_LOG2:0]   wr_ptr_r;
   logic [DEPTH_LOG2:0]   wr_commit_r;
   logic [DEPTH_LOG2:0]   rd_ptr_r;
   logic [DEPTH_LOG2:0]   wr_ptr_next_s;
   logic [DEPTH_LOG2:0]   wr_commit_next_s;
   logic [DEPTH_LOG2-1:0] mem_idx_s;
   logic                  mem_we_s;
   logic [1:0]            drop_inc_s;
   state_t                state_r;
   state_t                state_next_s;
   logic                  ready_r;
   logic                  full_s;
   logic                  in_beat_s;
   logic                  in_sop_s;
   logic                  in_eop_s;
   logic                  out_valid_s;
   logic                  rd_fire_s;
   logic [ENTRY_W-1:0]    head_s;

   // A new SOP always lands at wr_commit: in IDLE/DROP wr_ptr already equals it, in WRITE it rewinds.
   function automatic state_t sop_next(input logic eop, input logic full);
      if (eop) begin
         return ST_IDLE;
      end else if (full) begin
         return ST_DROP;
      end else begin
         return ST_WRITE;
      end
   endfunction

   assign full_s    = ((wr_ptr_r - rd_ptr_r) == PTR_DEPTH);
   assign in_beat_s = stream_in.valid & ready_r;
   assign in_sop_s  = stream_in.startofpacket;
   assign in_eop_s  = stream_in.endofpacket;

   // Input ready register: low while in reset, high from the first clock afterwards
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_r <= 1'b0;
      end else begin
         ready_r <= 1'b1;
      end
   end

   // Write FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Write FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      if (!in_beat_s) begin
         state_next_s = state_r;
      end else if (in_sop_s) begin
         state_next_s = sop_next(in_eop_s, full_s);
      end else begin
         case (state_r)
            ST_IDLE:  state_next_s = ST_IDLE;
            ST_WRITE: state_next_s = in_eop_s ? ST_IDLE : (full_s ? ST_DROP : ST_WRITE);
            ST_DROP:  state_next_s = in_eop_s ? ST_IDLE : ST_DROP;
            default:  state_next_s = ST_IDLE;
         endcase
      end
   end

   // Write FSM outputs: storage write, pointer moves and drop events
   always_comb begin
      mem_we_s         = 1'b0;
      mem_idx_s        = wr_ptr_r[DEPTH_LOG2-1:0];
      wr_ptr_next_s    = wr_ptr_r;
      wr_commit_next_s = wr_commit_r;
      drop_inc_s       = 2'd0;
      if (!in_beat_s) begin
         mem_we_s = 1'b0;
      end else if (in_sop_s) begin
         // Abandoned partial packet and a new SOP arriving while full each count as one drop
         drop_inc_s = {1'b0, (state_r == ST_WRITE)} + {1'b0, full_s};
         if (full_s) begin
            wr_ptr_next_s = wr_commit_r;
         end else begin
            mem_we_s      = 1'b1;
            mem_idx_s     = wr_commit_r[DEPTH_LOG2-1:0];
            wr_ptr_next_s = wr_commit_r + PTR_ONE;
            if (in_eop_s) begin
               wr_commit_next_s = wr_commit_r + PTR_ONE;
            end else begin
               wr_commit_next_s = wr_commit_r;
            end
         end
      end else if (state_r == ST_WRITE) begin
         if (full_s) begin
            wr_ptr_next_s = wr_commit_r;
            drop_inc_s    = 2'd1;
         end else begin
            mem_we_s      = 1'b1;
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            if (in_eop_s) begin
               wr_commit_next_s = wr_ptr_r + PTR_ONE;
            end else begin
               wr_commit_next_s = wr_commit_r;
            end
         end
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r    <= {(DEPTH_LOG2+1){1'b0}};
         wr_commit_r <= {(DEPTH_LOG2+1){1'b0}};
         rd_ptr_r    <= {(DEPTH_LOG2+1){1'b0}};
      end else begin
         wr_ptr_r    <= wr_ptr_next_s;
         wr_commit_r <= wr_commit_next_s;
         if (rd_fire_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Packet storage; contents deliberately left unreset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_idx_s] <= {stream_in.data, stream_in.empty, in_sop_s, in_eop_s};
      end
   end

   assign out_valid_s = (rd_ptr_r != wr_commit_r);
   assign rd_fire_s   = out_valid_s & stream_out.ready;
   assign head_s      = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];

   assign stream_in.ready          = ready_r;
   assign stream_out.valid         = out_valid_s;
   assign stream_out.data          = head_s[ENTRY_W-1 -: DATA_W];
   assign stream_out.empty         = head_s[EMPTY_W+1:2];
   assign stream_out.startofpacket = head_s[1];
   assign stream_out.endofpacket   = head_s[0];
   assign fill_level               = wr_ptr_r - rd_ptr_r;

`ifdef STREAM_PACKET_FIFO_STATS_EN
   logic [15:0] drop_count_r;
   logic [16:0] drop_sum_s;

   assign drop_sum_s = {1'b0, drop_count_r} + {15'd0, drop_inc_s};

   // Saturating discarded-packet counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_count_r <= 16'd0;
      end else if (drop_sum_s[16]) begin
         drop_count_r <= 16'hFFFF;
      end else begin
         drop_count_r <= drop_sum_s[15:0];
      end
   end

   assign drop_count = drop_count_r;
`else
   logic unused_drop_s;

   assign unused_drop_s = ^drop_inc_s;
   assign drop_count    = 16'd0;
`endif

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Directed and randomized packet traffic checked against a queue-based packet buffer model.
module tb_stream_packet_fifo;
   localparam int DB    = 8;
   localparam int DL2   = 5;
   localparam int DEPTH = 32;

   typedef struct packed {
      logic [63:0] d;
      logic [2:0]  e;
      logic        s;
      logic        eo;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [DL2:0]  fill_level;
   logic [15:0]   drop_count;

   stream_packet_fifo_if #(.DATA_BYTES(DB)) in_if ();
   stream_packet_fifo_if #(.DATA_BYTES(DB)) out_if ();

   stream_packet_fifo #(.DATA_BYTES(DB), .DEPTH_LOG2(DL2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .stream_in  (in_if),
      .stream_out (out_if),
      .fill_level (fill_level),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   beat_t cq[$];   // committed, visible beats
   beat_t pq[$];   // beats of the packet being written
   int    mode;    // 0 between packets, 1 storing a packet, 2 discarding a packet
   int    drops;
   int    checks;
   int    errors;
   bit    rand_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_drop();
`ifdef STREAM_PACKET_FIFO_STATS_EN
      logic [31:0] d;
      d = drops;
      return (d > 32'd65535) ? 64'hFFFF : {32'd0, d};
`else
      return 64'd0;
`endif
   endfunction

   task automatic commit();
      while (pq.size() > 0) cq.push_back(pq.pop_front());
   endtask

   task automatic start_packet(input beat_t b, input bit full);
      if (full) begin
         drops++;
         mode = b.eo ? 0 : 2;
      end else begin
         pq.push_back(b);
         if (b.eo) begin
            commit();
            mode = 0;
         end else begin
            mode = 1;
         end
      end
   endtask

   task automatic model_edge();
      bit    full;
      beat_t b;
      full = ((cq.size() + pq.size()) == DEPTH);
      b = {in_if.data, in_if.empty, in_if.startofpacket, in_if.endofpacket};
      if (out_if.ready && cq.size() > 0) void'(cq.pop_front());
      if (in_if.valid) begin
         if (b.s) begin
            if (mode == 1) begin
               pq.delete();
               drops++;
            end
            start_packet(b, full);
         end else if (mode == 1) begin
            if (full) begin
               pq.delete();
               drops++;
               mode = b.eo ? 0 : 2;
            end else begin
               pq.push_back(b);
               if (b.eo) begin
                  commit();
                  mode = 0;
               end
            end
         end else if (mode == 2 && b.eo) begin
            mode = 0;
         end
      end
   endtask

   task automatic step();
      if (rand_rdy) out_if.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("in_ready", 64'(in_if.ready), 64'd1);
      chk("out_valid", 64'(out_if.valid), 64'(cq.size() > 0));
      if (cq.size() > 0) begin
         chk("out_data", out_if.data, cq[0].d);
         chk("out_empty", 64'(out_if.empty), 64'(cq[0].e));
         chk("out_sop", 64'(out_if.startofpacket), 64'(cq[0].s));
         chk("out_eop", 64'(out_if.endofpacket), 64'(cq[0].eo));
      end
      chk("fill_level", 64'(fill_level), 64'(cq.size() + pq.size()));
      chk("drop_count", 64'(drop_count), exp_drop());
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic beat(input bit v, input logic [63:0] d, input logic [2:0] e,
                       input bit s, input bit eo);
      in_if.valid         = v;
      in_if.data          = d;
      in_if.empty         = e;
      in_if.startofpacket = s;
      in_if.endofpacket   = eo;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, {$urandom, $urandom}, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic packet(input int len, input logic [2:0] e, input bit with_eop);
      for (int i = 0; i < len; i++)
         beat(1'b1, {$urandom, $urandom}, (i == len - 1) ? e : 3'd0,
              (i == 0), with_eop && (i == len - 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(in_if.ready), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_if.valid), 64'd0);
      chk({tag, "_fill"}, 64'(fill_level), 64'd0);
      chk({tag, "_drops"}, 64'(drop_count), 64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drops = 0;
      mode = 0;
      rand_rdy = 1'b0;
      in_if.valid = 1'b0;
      in_if.data = 64'd0;
      in_if.empty = 3'd0;
      in_if.startofpacket = 1'b0;
      in_if.endofpacket = 1'b0;
      out_if.ready = 1'b1;

      #1 reset_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 3-beat packet with known first beat and empty=3 on EOP
      beat(1'b1, 64'h0102030405060708, 3'd0, 1'b1, 1'b0);
      beat(1'b1, 64'h1112131415161718, 3'd0, 1'b0, 1'b0);
      beat(1'b1, 64'h2122232425262728, 3'd3, 1'b0, 1'b1);
      idle(4);

      // Oversized packet is dropped whole; the next one passes
      packet(40, 3'd0, 1'b1);
      packet(2, 3'd5, 1'b1);
      idle(4);

      // Missing EOP: first packet discarded, second delivered
      packet(2, 3'd0, 1'b0);
      packet(2, 3'd1, 1'b1);
      idle(4);

      // Stray beats without SOP are ignored
      beat(1'b1, 64'hDEAD_BEEF_0000_0001, 3'd0, 1'b0, 1'b0);
      beat(1'b1, 64'hDEAD_BEEF_0000_0002, 3'd0, 1'b0, 1'b0);
      beat(1'b1, 64'hDEAD_BEEF_0000_0003, 3'd2, 1'b0, 1'b1);
      idle(2);

      // Fill with 4x8-beat packets under random backpressure, then a 31-beat packet
      rand_rdy = 1'b1;
      for (int p = 0; p < 4; p++) packet(8, 3'($urandom_range(0, 7)), 1'b1);
      packet(31, 3'd6, 1'b1);
      idle(60);

      // Random traffic including gaps, stray beats and missing EOPs
      for (int i = 0; i < 400; i++)
         beat(($urandom_range(0, 3) != 0), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      rand_rdy = 1'b0;
      out_if.ready = 1'b1;
      idle(40);

      // Reset mid-packet with a committed packet still buffered
      out_if.ready = 1'b0;
      packet(3, 3'd4, 1'b1);
      beat(1'b1, {$urandom, $urandom}, 3'd0, 1'b1, 1'b0);
      beat(1'b1, {$urandom, $urandom}, 3'd0, 1'b0, 1'b0);
      in_if.valid = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("midreset");
      cq.delete();
      pq.delete();
      mode = 0;
      drops = 0;
      out_if.ready = 1'b1;
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      packet(2, 3'd7, 1'b1);
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_packet_fifo.md
# stream_packet_fifo

Store-and-forward Avalon-ST packet buffer placed directly downstream of the endian swapper's output stream. A packet is written into an internal circular buffer and becomes visible on the output only once its end-of-packet beat has been stored, so downstream consumers never see partial packets. Packets that overflow the buffer, or are malformed, are discarded whole and counted.

## Interface
- DATA_BYTES, 8, bytes per beat; data width DATA_BYTES*8, empty width $clog2(DATA_BYTES)
- DEPTH_LOG2, 5, buffer depth = 2**DEPTH_LOG2 beats
- clk  input  1  clock; all logic on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- stream_in_data  input  DATA_BYTES*8  beat data
- stream_in_empty  input  $clog2(DATA_BYTES)  unused bytes on EOP beat
- stream_in_valid  input  1  beat valid
- stream_in_startofpacket  input  1  SOP
- stream_in_endofpacket  input  1  EOP
- stream_in_ready  output  1  0 in reset, 1 otherwise (never backpressures; overflow drops)
- stream_out_data  output  DATA_BYTES*8  head-of-buffer data
- stream_out_empty  output  $clog2(DATA_BYTES)  head empty
- stream_out_valid  output  1  committed beat available
- stream_out_startofpacket  output  1  head SOP
- stream_out_endofpacket  output  1  head EOP
- stream_out_ready  input  1  downstream accepts; readyLatency 0
- fill_level  output  DEPTH_LOG2+1  wr_ptr - rd_ptr (includes uncommitted beats)
- drop_count  output  16  packets discarded, saturating at 16'hFFFF

## Operation
- Storage entry = {data, empty, sop, eop}; array of 2**DEPTH_LOG2 entries, combinational read at rd_ptr.
- Pointers wr_ptr, wr_commit, rd_ptr: DEPTH_LOG2+1 bits, wrap modulo 2**(DEPTH_LOG2+1); index = low DEPTH_LOG2 bits.
- full = (wr_ptr - rd_ptr == 2**DEPTH_LOG2), from registered values at cycle start.
- Write FSM states: IDLE, WRITE, DROP.
  - IDLE: valid&SOP -> store beat, wr_ptr+1; if also EOP, wr_commit<=wr_ptr+1, stay IDLE; else -> WRITE. Valid without SOP: beat discarded, not counted. SOP while full: -> DROP (or stay IDLE if also EOP), drop_count+1.
  - WRITE: valid&!SOP&!full -> store; on EOP commit wr_commit<=wr_ptr+1, -> IDLE. Valid while full -> wr_ptr<=wr_commit, drop_count+1, -> DROP (IDLE if EOP). Valid&SOP (missing EOP) -> wr_ptr rewinds to wr_commit, drop_count+1, new SOP beat then handled as in IDLE from the rewound pointer, same cycle.
  - DROP: discard beats until EOP -> IDLE. SOP in DROP: handled as in IDLE (previous packet already counted).
- Read: stream_out_valid = (rd_ptr != wr_commit); rd_ptr+1 when valid&ready.
- Simultaneous read and write: both pointers update; write still uses start-of-cycle full (no same-cycle slot reuse).
- drop_count increments once per discarded packet, saturates.

## Timing
- Reset (async assert): wr_ptr=wr_commit=rd_ptr=0, FSM IDLE, stream_in_ready=0, stream_out_valid=0, fill_level=0, drop_count=0; stream_out_data/empty/sop/eop reflect entry 0 and are don't-care while valid=0. Memory contents not reset.
- EOP accepted at edge N -> stream_out_valid high in cycle after N (1-cycle store-to-visible latency).
- Full-rate output: one beat per cycle while committed beats remain and ready=1.
- stream_out_* stable while valid&!ready.
- Reset mid-packet: buffered and partial packets lost; no drop counted.

## Configuration
- STREAM_PACKET_FIFO_STATS_EN defined: drop_count logic as above.
- Not defined: drop_count tied to 16'd0, counter registers absent; drop behaviour unchanged.

## Test plan
- 3-beat packet (SOP beat 0x0102030405060708, EOP empty=3), out_ready=1 -> out_valid rises cycle after EOP, 3 beats identical, empty=3, drop_count=0.
- DEPTH_LOG2=5, 40-beat packet -> dropped, no output, drop_count=1, fill_level returns to 0; following 2-beat packet passes intact.
- SOP, 2 beats, new SOP without EOP, 2-beat packet -> only second packet output, drop_count=1.
- Beats with valid but no SOP in IDLE -> ignored, drop_count=0, fill_level=0.
- Fill with 4×8-beat packets, out_ready toggled randomly, then 31-beat packet while full drains -> order preserved, wrap-around correct, no beat loss on committed packets.
- Assert reset_n low mid-packet -> all outputs at reset values asynchronously; post-reset packet passes.
